sdram_probe_clear: RTL and testbench
====================================

Name: sdram_probe_clear

Overview:
- Sequencer that owns the SDRAM controller command port at startup.
- Runs a size-probe sequence of aliasing writes and read-backs and reports the result as a config mask for the HPS menu mask.
- Then sweeps the whole address space, writing zeros continuously, so that later cores start from clean RAM.
- Sits between the pll/locked logic and the sdram controller instance in the menu core.

Parameters:
- ADDR_W, 27, width of mem_addr.
- CLEAR_END, 27'h1FFFFFF, last address written in the clear sweep; the sweep wraps to 0 after it.
- CLEAR_GAP, 31, idle cycles between consecutive clear writes (throttle; 0 = back-to-back when ready).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mem_ready  in  1  controller ready/idle; also qualifies mem_dout.
- mem_dout  in  16  controller read data.
- mem_addr  out  ADDR_W  command address.
- mem_din  out  16  write data.
- mem_we  out  1  one-cycle write strobe.
- mem_rd  out  1  one-cycle read strobe.
- cfg  out  16  bit0/1/2 = region at 'h0000000/'h2000000/'h4000000 verified; bit15 = probe done; other bits 0.
- clearing  out  1  high while in the clear phase.
- pass_cnt  out  8  completed clear sweeps, saturating at 255.

Behaviour:
- Reset (async assert, sync-released logic): all outputs 0, FSM in WAIT_RDY, gap counter 0. Reset at any point, including mid-command, abandons the sequence. Strobes drop immediately. cfg clears to 0 and the probe restarts after release.
- Command rule: mem_we/mem_rd are single-cycle pulses issued only in a cycle where mem_ready=1. mem_addr/mem_din are registered in that same cycle and held until the next command. After each command the FSM spends exactly one cycle in a SKIP state, ignoring mem_ready, then waits for mem_ready=1.
- Never assert mem_we and mem_rd together.
- FSM order: WAIT_RDY → W4 → W2 → W0 → W1 → R4 → R2 → R0 → DONE → CLEAR.
  - WAIT_RDY: cfg<=0; advance on mem_ready.
  - W4: write 'h4000000 = 3128.
  - W2: write 'h2000000 = 2064.
  - W0: write 'h0000000 = 1032.
  - W1: write 'h1000000 = 12345 (bus-flush dummy).
  - R4: read 'h4000000.
  - R2: on ready, cfg[2] <= (mem_dout==3128); read 'h2000000.
  - R0: on ready, cfg[1] <= (mem_dout==2064); read 'h0000000.
  - DONE: on ready, cfg[0] <= (mem_dout==1032); cfg[15] <= 1; clear address <= 0; gap counter <= CLEAR_GAP.
  - CLEAR: clearing=1.
    - Gap counter decrements to 0.
    - When the counter is 0 and mem_ready=1, write 0 to the clear address, reload the counter to CLEAR_GAP, and increment the address.
    - If mem_ready=0 when the counter hits 0, the write is held pending; there is no skipped address and no double write.
    - At address == CLEAR_END, the next address is 0 and pass_cnt increments, saturating at 255.
    - CLEAR never exits except by reset.
- cfg[14:3] is always 0. cfg bits stay stable once bit15 is set.
- Probe latency is the sum of controller busy times plus 1 cycle per command and 1 cycle for WAIT_RDY; there are no other added cycles.

Test Plan:
- Full-size model (no aliasing), mem_ready toggling with a 6-cycle busy per command: 7 commands in W4..R0 order with the exact addresses/data above; cfg = 16'h8007; clearing rises in the cycle after DONE.
- Model ignoring addr bit 26: cfg = 16'h8003. Model ignoring bits 26:25: cfg = 16'h8001. Model returning constant 0: cfg = 16'h8000.
- CLEAR_GAP=3, mem_ready held 1: clear writes every 4 cycles to addresses 0,1,2,3… with mem_din=0. Checker flags any cycle with we&rd or a strobe while mem_ready=0.
- CLEAR_END=7, CLEAR_GAP=0: after address 7 the next write is to 0; pass_cnt 0→1. After 300 wraps, pass_cnt = 255.
- Drop mem_ready for 20 cycles while the gap counter is 0: exactly one write occurs on return, to the next sequential address.
- Assert reset mid-CLEAR and again mid-R2: outputs go to 0 asynchronously. After release the probe sequence restarts from W4, cfg rebuilds to 16'h8007, and pass_cnt restarts at 0.

Source files
------------

// File: rtl/sdram_probe_clear.sv
// Startup sequencer for the SDRAM command port: probes the usable size through
// aliasing writes and read-backs, then keeps sweeping the whole array with zeros.
`timescale 1ns/1ps
module sdram_probe_clear #(
  parameter int unsigned             ADDR_W    = 27,
  parameter logic [ADDR_W-1:0]       CLEAR_END = 27'h1FFFFFF,
  parameter int unsigned             CLEAR_GAP = 31
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic [15:0]       mem_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  output logic [15:0]       cfg,
  output logic              clearing,
  output logic [7:0]        pass_cnt
);

  localparam int unsigned GAP_W = (CLEAR_GAP < 2) ? 1 : $clog2(CLEAR_GAP + 1);

  typedef enum logic [3:0] {
    S_WAIT_RDY, S_W4, S_W2, S_W0, S_W1, S_R4, S_R2, S_R0, S_DONE, S_CLEAR, S_SKIP
  } state_t;

  state_t            state_q, state_d, ret_q, ret_d;
  logic [ADDR_W-1:0] addr_q, addr_d, clr_addr_q, clr_addr_d;
  logic [15:0]       din_q, din_d;
  logic              we_q, we_d, rd_q, rd_d;
  logic [2:0]        ver_q, ver_d;
  logic              done_q, done_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        pass_q, pass_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT_RDY;
      ret_q      <= S_WAIT_RDY;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      ver_q      <= '0;
      done_q     <= 1'b0;
      clr_addr_q <= '0;
      gap_q      <= '0;
      pass_q     <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      ver_q      <= ver_d;
      done_q     <= done_d;
      clr_addr_q <= clr_addr_d;
      gap_q      <= gap_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    rd_d       = 1'b0;
    ver_d      = ver_q;
    done_d     = done_q;
    clr_addr_d = clr_addr_q;
    pass_d     = pass_q;
    gap_d      = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;

    // Every command is followed by one SKIP cycle, so the controller has seen
    // the registered strobe before mem_ready is trusted again.
    case (state_q)
      S_WAIT_RDY: begin
        ver_d  = '0;
        done_d = 1'b0;
        if (mem_ready) state_d = S_W4;
      end
      S_W4: if (mem_ready) begin
        we_d = 1'b1; addr_d = ADDR_W'(27'h4000000); din_d = 16'd3128;
        state_d = S_SKIP; ret_d = S_W2;
      end
      S_W2: if (mem_ready) begin
        we_d = 1'b1; addr_d = ADDR_W'(27'h2000000); din_d = 16'd2064;
        state_d = S_SKIP; ret_d = S_W0;
      end
      S_W0: if (mem_ready) begin
        we_d = 1'b1; addr_d = '0; din_d = 16'd1032;
        state_d = S_SKIP; ret_d = S_W1;
      end
      S_W1: if (mem_ready) begin
        we_d = 1'b1; addr_d = ADDR_W'(27'h1000000); din_d = 16'd12345;
        state_d = S_SKIP; ret_d = S_R4;
      end
      S_R4: if (mem_ready) begin
        rd_d = 1'b1; addr_d = ADDR_W'(27'h4000000);
        state_d = S_SKIP; ret_d = S_R2;
      end
      S_R2: if (mem_ready) begin
        ver_d[2] = (mem_dout == 16'd3128);
        rd_d = 1'b1; addr_d = ADDR_W'(27'h2000000);
        state_d = S_SKIP; ret_d = S_R0;
      end
      S_R0: if (mem_ready) begin
        ver_d[1] = (mem_dout == 16'd2064);
        rd_d = 1'b1; addr_d = '0;
        state_d = S_SKIP; ret_d = S_DONE;
      end
      S_DONE: if (mem_ready) begin
        ver_d[0]   = (mem_dout == 16'd1032);
        done_d     = 1'b1;
        clr_addr_d = '0;
        gap_d      = GAP_W'(CLEAR_GAP);
        state_d    = S_CLEAR;
      end
      S_CLEAR: if (gap_q == '0 && mem_ready) begin
        we_d   = 1'b1;
        addr_d = clr_addr_q;
        din_d  = '0;
        gap_d  = GAP_W'(CLEAR_GAP);
        if (clr_addr_q == CLEAR_END) begin
          clr_addr_d = '0;
          if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
        state_d = S_SKIP; ret_d = S_CLEAR;
      end
      S_SKIP:  state_d = ret_q;
      default: state_d = S_WAIT_RDY;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_we   = we_q;
  assign mem_rd   = rd_q;
  assign cfg      = {done_q, 12'h000, ver_q};
  // done_q is set on the same edge that enters CLEAR and only reset clears it.
  assign clearing = done_q;
  assign pass_cnt = pass_q;

endmodule

// File: tb/tb_sdram_probe_clear.sv
// Directed bench: SDRAM controller model with selectable address aliasing
// drives instance A; instance B has an always-ready, zero-data controller.
`timescale 1ns/1ps
module tb_sdram_probe_clear;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_ready, a_we, a_rd, a_clearing;
  logic [15:0] a_dout, a_din, a_cfg;
  logic [26:0] a_addr;
  logic [7:0]  a_pass;

  logic        b_ready, b_we, b_rd, b_clearing;
  logic [15:0] b_dout, b_din, b_cfg;
  logic [26:0] b_addr;
  logic [7:0]  b_pass;
  assign b_ready = 1'b1;
  assign b_dout  = 16'h0000;

  sdram_probe_clear #(.ADDR_W(27), .CLEAR_END(27'd7), .CLEAR_GAP(3)) dut_a (
    .clk_sys(clk), .reset(rst), .mem_ready(a_ready), .mem_dout(a_dout),
    .mem_addr(a_addr), .mem_din(a_din), .mem_we(a_we), .mem_rd(a_rd),
    .cfg(a_cfg), .clearing(a_clearing), .pass_cnt(a_pass));

  sdram_probe_clear #(.ADDR_W(27), .CLEAR_END(27'd7), .CLEAR_GAP(0)) dut_b (
    .clk_sys(clk), .reset(rst), .mem_ready(b_ready), .mem_dout(b_dout),
    .mem_addr(b_addr), .mem_din(b_din), .mem_we(b_we), .mem_rd(b_rd),
    .cfg(b_cfg), .clearing(b_clearing), .pass_cnt(b_pass));

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int cyc    = 0;

  // Controller model for instance A
  int          mode      = 0;  // 0 full, 1 ignore bit26, 2 ignore bits 26:25, 3 reads 0
  int          busy_len  = 6;
  logic        hold_low  = 1'b0;
  logic        ready_int;
  int          busy;
  logic [15:0] pend;
  logic [15:0] mem [int];
  assign a_ready = ready_int & ~hold_low;

  function automatic int maddr(input logic [26:0] a, input int m);
    logic [26:0] x;
    x = a;
    if (m == 1) x[26] = 1'b0;
    if (m == 2) x[26:25] = 2'b00;
    return int'(x);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [15:0] rdata;
    rdata = '0;
    if (rst) begin
      busy <= 0; ready_int <= 1'b1; a_dout <= '0; pend <= '0;
    end else if (a_we || a_rd) begin
      if (a_we) mem[maddr(a_addr, mode)] = a_din;
      if (a_rd && mode != 3 && mem.exists(maddr(a_addr, mode))) rdata = mem[maddr(a_addr, mode)];
      if (busy_len == 0) begin
        if (a_rd) a_dout <= rdata;
      end else begin
        busy <= busy_len; ready_int <= 1'b0; pend <= rdata;
      end
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy <= 0; ready_int <= 1'b1; a_dout <= pend;
    end
  end

  typedef struct {
    logic        we;
    logic [26:0] addr;
    logic [15:0] din;
    int          cyc;
    logic [7:0]  pass;
  } cmd_t;
  cmd_t a_log[$];
  cmd_t b_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor and command logger, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if ((a_we && a_rd) || ((a_we || a_rd) && !a_ready)) viol <= viol + 1;
      if ((b_we && b_rd) || ((b_we || b_rd) && !b_ready)) viol <= viol + 1;
      if (a_we || a_rd) a_log.push_back('{a_we, a_addr, a_din, cyc, a_pass});
      if (b_we) b_log.push_back('{b_we, b_addr, b_din, cyc, b_pass});
    end
  end

  logic [26:0] exp_addr [7] = '{27'h4000000, 27'h2000000, 27'h0000000, 27'h1000000,
                                27'h4000000, 27'h2000000, 27'h0000000};
  logic        exp_we   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] exp_din  [4] = '{16'd3128, 16'd2064, 16'd1032, 16'd12345};

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name, output logic ok);
    for (int i = 0; i < 400 && !a_cfg[15]; i++) @(negedge clk);
    ok = a_cfg[15];
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: cfg=%h required bit15 set", name, a_cfg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (a_we !== 1'b0)       begin errors++; $display("FAIL rst_we got %b want 0", a_we); end
    if (a_rd !== 1'b0)       begin errors++; $display("FAIL rst_rd got %b want 0", a_rd); end
    if (a_addr !== '0)       begin errors++; $display("FAIL rst_addr got %h want 0", a_addr); end
    if (a_din !== '0)        begin errors++; $display("FAIL rst_din got %h want 0", a_din); end
    if (a_cfg !== '0)        begin errors++; $display("FAIL rst_cfg got %h want 0", a_cfg); end
    if (a_clearing !== 1'b0) begin errors++; $display("FAIL rst_clearing got %b want 0", a_clearing); end
    if (a_pass !== '0)       begin errors++; $display("FAIL rst_pass got %0d want 0", a_pass); end
    rst = 1'b0;
  endtask

  task automatic test_probe_full();
    int   base;
    logic ok;
    logic prev_clr;
    mode = 0; busy_len = 6;
    do_reset();
    base = a_log.size();
    prev_clr = 1'b1;
    for (int i = 0; i < 400 && !a_cfg[15]; i++) begin
      prev_clr = a_clearing;
      @(negedge clk);
    end
    wait_done("probe_full", ok);
    checks++;
    if (a_cfg !== 16'h8007) begin errors++; $display("FAIL probe_full_cfg got %h want 8007", a_cfg); end
    checks++;
    if (prev_clr !== 1'b0 || a_clearing !== 1'b1) begin
      errors++; $display("FAIL probe_clearing_edge got %b->%b want 0->1", prev_clr, a_clearing);
    end
    checks++;
    if (a_log.size() - base != 7) begin
      errors++; $display("FAIL probe_cmd_count got %0d want 7", a_log.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (a_log[base+i].we !== exp_we[i] || a_log[base+i].addr !== exp_addr[i] ||
            (exp_we[i] && a_log[base+i].din !== exp_din[i])) begin
          errors++;
          $display("FAIL probe_cmd%0d got we=%b addr=%h din=%0d want we=%b addr=%h", i,
                   a_log[base+i].we, a_log[base+i].addr, a_log[base+i].din, exp_we[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_alias();
    logic [15:0] exp_cfg [3] = '{16'h8003, 16'h8001, 16'h8000};
    logic ok;
    for (int m = 1; m <= 3; m++) begin
      mode = m; busy_len = 6;
      do_reset();
      wait_done("alias", ok);
      checks++;
      if (a_cfg !== exp_cfg[m-1]) begin
        errors++; $display("FAIL alias_mode%0d_cfg got %h want %h", m, a_cfg, exp_cfg[m-1]);
      end
    end
  endtask

  task automatic test_clear_gap();
    int   base;
    logic ok;
    mode = 0; busy_len = 0;
    do_reset();
    wait_done("gap_probe", ok);
    base = a_log.size();
    for (int i = 0; i < 100 && a_log.size() - base < 5; i++) @(negedge clk);
    checks++;
    if (a_log.size() - base < 5) begin
      errors++; $display("FAIL gap_count got %0d want 5", a_log.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (a_log[base+i].we !== 1'b1 || a_log[base+i].addr !== 27'(i) || a_log[base+i].din !== 16'h0 ||
            (i > 0 && a_log[base+i].cyc - a_log[base+i-1].cyc != 4)) begin
          errors++;
          $display("FAIL gap_write%0d got we=%b addr=%h din=%h at cyc %0d want addr=%0d din=0 spacing 4", i,
                   a_log[base+i].we, a_log[base+i].addr, a_log[base+i].din, a_log[base+i].cyc, i);
        end
      end
    end
  endtask

  task automatic test_ready_drop();
    int          base;
    logic [26:0] last;
    base = a_log.size();
    for (int i = 0; i < 20 && a_log.size() == base; i++) @(negedge clk);
    checks++;
    if (a_log.size() == base) begin
      errors++; $display("FAIL drop_prewrite timeout got 0 writes want 1");
    end else begin
      last = a_log[a_log.size()-1].addr;
      hold_low = 1'b1;
      base = a_log.size();
      repeat (20) @(negedge clk);
      checks++;
      if (a_log.size() != base) begin
        errors++; $display("FAIL drop_held got %0d writes want 0", a_log.size() - base);
      end
      hold_low = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (a_log.size() - base != 1 || a_log[base].addr !== ((last == 27'd7) ? 27'd0 : last + 27'd1)) begin
        errors++;
        $display("FAIL drop_resume got %0d writes addr=%h want 1 write after %h", a_log.size() - base,
                 (a_log.size() > base) ? a_log[base].addr : 27'h0, last);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   base;
    logic ok;
    // mid-CLEAR
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_clearing !== 1'b0 || a_cfg !== '0 || a_we !== 1'b0 || a_rd !== 1'b0 || a_pass !== '0) begin
      errors++; $display("FAIL midclear_async got clr=%b cfg=%h we=%b rd=%b pass=%0d want all 0",
                         a_clearing, a_cfg, a_we, a_rd, a_pass);
    end
    @(negedge clk);
    rst = 1'b0;
    // mid-R2
    mode = 0; busy_len = 6;
    base = a_log.size();
    for (int i = 0; i < 200 && a_log.size() - base < 5; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (a_log.size() - base != 5 || a_addr !== 27'h4000000) begin
      errors++; $display("FAIL midr2_setup got %0d cmds addr=%h want 5 cmds addr=4000000", a_log.size() - base, a_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_addr !== '0 || a_din !== '0 || a_we !== 1'b0 || a_rd !== 1'b0 || a_cfg !== '0) begin
      errors++; $display("FAIL midr2_async got addr=%h din=%h we=%b rd=%b cfg=%h want all 0",
                         a_addr, a_din, a_we, a_rd, a_cfg);
    end
    @(negedge clk);
    rst = 1'b0;
    base = a_log.size();
    wait_done("restart", ok);
    checks++;
    if (a_cfg !== 16'h8007 || a_pass !== 8'd0) begin
      errors++; $display("FAIL restart_cfg got cfg=%h pass=%0d want 8007 pass=0", a_cfg, a_pass);
    end
    checks++;
    if (a_log.size() - base != 7) begin
      errors++; $display("FAIL restart_cmd_count got %0d want 7", a_log.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (a_log[base+i].we !== exp_we[i] || a_log[base+i].addr !== exp_addr[i]) begin
          errors++; $display("FAIL restart_cmd%0d got we=%b addr=%h want we=%b addr=%h", i,
                             a_log[base+i].we, a_log[base+i].addr, exp_we[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int base;
    do_reset();
    for (int i = 0; i < 200 && !b_cfg[15]; i++) @(negedge clk);
    checks++;
    if (b_cfg !== 16'h8000) begin errors++; $display("FAIL wrap_cfg got %h want 8000", b_cfg); end
    base = b_log.size();
    for (int i = 0; i < 100 && b_log.size() - base < 9; i++) @(negedge clk);
    checks++;
    if (b_log.size() - base < 9) begin
      errors++; $display("FAIL wrap_count got %0d want 9", b_log.size() - base);
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (b_log[base+i].addr !== 27'(i % 8)) begin
          errors++; $display("FAIL wrap_addr%0d got %h want %0d", i, b_log[base+i].addr, i % 8);
        end
      end
      checks += 3;
      if (b_log[base].pass !== 8'd0) begin errors++; $display("FAIL wrap_pass0 got %0d want 0", b_log[base].pass); end
      if (b_log[base+8].pass !== 8'd1) begin errors++; $display("FAIL wrap_pass1 got %0d want 1", b_log[base+8].pass); end
      if (b_log[base+8].cyc - b_log[base+7].cyc != 2) begin
        errors++; $display("FAIL wrap_spacing got %0d want 2", b_log[base+8].cyc - b_log[base+7].cyc);
      end
    end
    repeat (4900) @(negedge clk);
    checks++;
    if (b_pass !== 8'd255) begin errors++; $display("FAIL wrap_saturate got %0d want 255", b_pass); end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL protocol_violations got %0d want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_probe_full();
    test_alias();
    test_clear_gap();
    test_ready_drop();
    test_reset_mid();
    test_wrap();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
